instr_fetch_stage: RTL

//   Stage 1 of four_stage_pipelined_processor: owns the program counter.
//   - Reads instruction memory (combinational read port) each cycle.
//   - Loads the IF/ID pipeline register consumed by the decode stage.
//   - Honours decode/execute stall and branch-redirect requests.
//   - Stops fetching after a HALT opcode is fetched.

---
 rtl/instr_fetch_stage_if.sv | 26 ++
 rtl/instr_fetch_stage.sv | 89 ++++++++
 2 files changed

// File: rtl/instr_fetch_stage_if.sv
// Fetch-stage bus: instruction memory read port, decode/execute control, IF/ID outputs.
interface instr_fetch_stage_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               stall;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic [INSTR_W-1:0] ifid_instr;
  logic [ADDR_W-1:0]  ifid_pc;
  logic               ifid_valid;
  logic               halted;
  logic [15:0]        fetch_count;

  modport master (
    output imem_addr, ifid_instr, ifid_pc, ifid_valid, halted, fetch_count,
    input  imem_rdata, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_addr, ifid_instr, ifid_pc, ifid_valid, halted, fetch_count,
    output imem_rdata, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// Pipeline stage 1: owns the PC, reads instruction memory and loads the IF/ID register.
module instr_fetch_stage #(
  parameter int                 ADDR_W    = 8,
  parameter int                 INSTR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [3:0]         HALT_OPC  = 4'hF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input logic                  clk,
  input logic                  reset,
  instr_fetch_stage_if.master  bus
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t             state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  ifid_pc_q;
  logic               valid_q;
  logic               halted_q;
  logic [15:0]        fetch_cnt_q, fetch_cnt_d;
  logic               is_halt;

  assign fetch_cnt_d = (&fetch_cnt_q) ? fetch_cnt_q : fetch_cnt_q + 16'd1;
  assign is_halt     = (bus.imem_rdata[INSTR_W-1 -: 4] == HALT_OPC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      instr_q     <= NOP_INSTR;
      ifid_pc_q   <= '0;
      valid_q     <= 1'b0;
      halted_q    <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (bus.redirect) begin
            pc_q      <= bus.redirect_pc;
            instr_q   <= NOP_INSTR;
            ifid_pc_q <= '0;
            valid_q   <= 1'b0;
          end else if (!bus.stall) begin
            instr_q     <= bus.imem_rdata;
            ifid_pc_q   <= pc_q;
            valid_q     <= 1'b1;
            fetch_cnt_q <= fetch_cnt_d;
            // PC parks on the HALT address so imem_addr reports where fetch stopped
            if (is_halt) begin
              state_q  <= HALTED;
              halted_q <= 1'b1;
            end else begin
              pc_q <= pc_q + ADDR_W'(1);
            end
          end
        end
        HALTED: begin
          if (bus.redirect) begin
            // HALT fetched in a branch shadow is cancelled by the redirect
            pc_q      <= bus.redirect_pc;
            instr_q   <= NOP_INSTR;
            ifid_pc_q <= '0;
            valid_q   <= 1'b0;
            state_q   <= RUN;
            halted_q  <= 1'b0;
          end else if (!bus.stall) begin
            instr_q   <= NOP_INSTR;
            ifid_pc_q <= '0;
            valid_q   <= 1'b0;
          end
        end
        default: begin
          state_q  <= RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.ifid_instr  = instr_q;
  assign bus.ifid_pc     = ifid_pc_q;
  assign bus.ifid_valid  = valid_q;
  assign bus.halted      = halted_q;
  assign bus.fetch_count = fetch_cnt_q;

endmodule
